// File: rtl/ifu_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : ifu_pc_gen_pkg
// Brief  : Shared types and constants for the IFU program-counter generator.
// Rev    : 1.0  initial release
// ============================================================================
package ifu_pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifu_pcgen_state_e;

    localparam logic [31:0] c_rst_pc_default = 32'h8000_0000;

    function automatic bit fetch_w_legal(input int fetch_w);
        return (fetch_w == 1) || (fetch_w == 2) || (fetch_w == 4);
    endfunction

    // Width of the slot-offset field inside a fetch group (never below 1 bit).
    function automatic int lane_off_w(input int fetch_w);
        return (fetch_w > 1) ? $clog2(fetch_w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_pc_lane_mask.sv
`default_nettype none
// ============================================================================
// Module : ifu_pc_lane_mask
// Brief  : Slot offset within a fetch group -> per-lane instruction valid mask.
// Rev    : 1.0  initial release
// ============================================================================
module ifu_pc_lane_mask
    import ifu_pc_gen_pkg::*;
#(
    parameter int FETCH_W = 1
) (
    input  logic [lane_off_w(FETCH_W)-1:0] pc_offset,
    output logic [FETCH_W-1:0]             lane_mask
);

    localparam int c_off_w = lane_off_w(FETCH_W);

    generate
        if (FETCH_W == 1) begin : g_single
            logic w_unused_offset;
            assign w_unused_offset = pc_offset[0];
            assign lane_mask       = 1'b1;
        end else begin : g_multi
            // Slots below the entry offset belong to the previous group.
            for (genvar i = 0; i < FETCH_W; i++) begin : g_lane
                assign lane_mask[i] = (pc_offset <= c_off_w'(i));
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ifu_pc_gen.sv
`default_nettype none
// ============================================================================
// Module : ifu_pc_gen
// Brief  : Fetch PC generator with trap/branch redirects and boot/run/halt FSM.
// Rev    : 1.0  initial release
// ============================================================================
module ifu_pc_gen
    import ifu_pc_gen_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] RST_PC  = XLEN'(c_rst_pc_default),
    parameter int              FETCH_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trap_redirect,
    input  logic [XLEN-1:0]    trap_target,
    input  logic               br_redirect,
    input  logic [XLEN-1:0]    br_target,
    input  logic               halt_req,
    input  logic               resume,
    input  logic               pc_ready,
    output logic [XLEN-1:0]    pc,
    output logic               pc_valid,
    output logic [FETCH_W-1:0] lane_mask,
    output logic               pc_fire,
    output logic               misalign_err,
    output logic               halted
);

    localparam int              c_off_w     = lane_off_w(FETCH_W);
    localparam logic [XLEN-1:0] c_grp_bytes = XLEN'(FETCH_W * 4);
    localparam logic [XLEN-1:0] c_grp_mask  = ~(c_grp_bytes - XLEN'(1));

    generate
        if (!fetch_w_legal(FETCH_W)) begin : g_bad_fetch_w
            $error("ifu_pc_gen: FETCH_W must be 1, 2 or 4");
        end
        if (RST_PC[1:0] != 2'b00) begin : g_bad_rst_pc
            $error("ifu_pc_gen: RST_PC must be 4-byte aligned");
        end
    endgenerate

    ifu_pcgen_state_e r_state;
    ifu_pcgen_state_e w_state_next;
    logic [XLEN-1:0]  r_pc;
    logic             r_valid;
    logic             r_halted;
    logic             r_fire;
    logic             r_misalign;

    logic             w_redirect;
    logic [XLEN-1:0]  w_target;
    logic             w_handshake;
    logic [XLEN-1:0]  w_seq_pc;
    logic [XLEN-1:0]  w_pc_next;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     if (halt_req) w_state_next = HALT;
            HALT:    if (resume)   w_state_next = RUN;
            default: w_state_next = BOOT;
        endcase
    end

    // Trap outranks branch; both are honoured in RUN and HALT but not BOOT.
    always_comb begin
        w_redirect = 1'b0;
        w_target   = '0;
        if (r_state != BOOT) begin
            if (trap_redirect) begin
                w_redirect = 1'b1;
                w_target   = trap_target;
            end else if (br_redirect) begin
                w_redirect = 1'b1;
                w_target   = br_target;
            end
        end

        w_handshake = r_valid && pc_ready;
        w_seq_pc    = (r_pc & c_grp_mask) + c_grp_bytes;

        if (w_redirect) begin
            w_pc_next = {w_target[XLEN-1:2], 2'b00};
        end else if (w_handshake) begin
            w_pc_next = w_seq_pc;
        end else begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= BOOT;
            r_pc       <= RST_PC;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_fire     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_valid    <= (w_state_next == RUN);
            r_halted   <= (w_state_next == HALT);
            r_fire     <= w_handshake;
            r_misalign <= w_redirect && (w_target[1:0] != 2'b00);
        end
    end

    ifu_pc_lane_mask #(
        .FETCH_W (FETCH_W)
    ) u_lane_mask (
        .pc_offset (r_pc[c_off_w+1:2]),
        .lane_mask (lane_mask)
    );

    assign pc           = r_pc;
    assign pc_valid     = r_valid;
    assign halted       = r_halted;
    assign pc_fire      = r_fire;
    assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_ifu_pc_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_ifu_pc_gen
// Brief  : Self-checking bench driving FETCH_W=1 and FETCH_W=4 instances.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ifu_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trap_redirect = 1'b0;
    logic [31:0] trap_target   = '0;
    logic        br_redirect   = 1'b0;
    logic [31:0] br_target     = '0;
    logic        halt_req      = 1'b0;
    logic        resume        = 1'b0;
    logic        pc_ready      = 1'b0;

    logic [31:0] p1_pc,    p4_pc;
    logic        p1_valid, p4_valid;
    logic [0:0]  p1_mask;
    logic [3:0]  p4_mask;
    logic        p1_fire,  p4_fire;
    logic        p1_mis,   p4_mis;
    logic        p1_halted, p4_halted;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    ifu_pc_gen #(.XLEN(32), .RST_PC(32'h8000_0000), .FETCH_W(1)) dut1 (
        .clk(clk), .rst(rst),
        .trap_redirect(trap_redirect), .trap_target(trap_target),
        .br_redirect(br_redirect), .br_target(br_target),
        .halt_req(halt_req), .resume(resume), .pc_ready(pc_ready),
        .pc(p1_pc), .pc_valid(p1_valid), .lane_mask(p1_mask),
        .pc_fire(p1_fire), .misalign_err(p1_mis), .halted(p1_halted)
    );

    ifu_pc_gen #(.XLEN(32), .RST_PC(32'h8000_0000), .FETCH_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .trap_redirect(trap_redirect), .trap_target(trap_target),
        .br_redirect(br_redirect), .br_target(br_target),
        .halt_req(halt_req), .resume(resume), .pc_ready(pc_ready),
        .pc(p4_pc), .pc_valid(p4_valid), .lane_mask(p4_mask),
        .pc_fire(p4_fire), .misalign_err(p4_mis), .halted(p4_halted)
    );

    // ------------------------------------------------------------------
    // Behavioural model: mode 0 = boot, 1 = run, 2 = halt; index 0 is the
    // 4-byte-group instance, index 1 the 16-byte-group instance.
    // ------------------------------------------------------------------
    int          g_bytes [2] = '{4, 16};
    logic [31:0] m_pc    [2];
    int          m_mode  [2];
    logic        m_fire  [2];
    logic        m_mis   [2];

    function automatic logic [31:0] mdl_next_pc(input logic [31:0] cur, input int mode, input int g);
        logic [31:0] gb = 32'(g);
        if (mode != 0 && trap_redirect) return trap_target & ~32'd3;
        if (mode != 0 && br_redirect)   return br_target & ~32'd3;
        if (mode == 1 && pc_ready)      return cur - (cur % gb) + gb;
        return cur;
    endfunction

    function automatic logic mdl_mis(input int mode);
        if (mode == 0)     return 1'b0;
        if (trap_redirect) return (trap_target % 4) != 0;
        if (br_redirect)   return (br_target % 4) != 0;
        return 1'b0;
    endfunction

    function automatic int mdl_mode(input int mode);
        if (mode == 0)             return 1;
        if (mode == 1 && halt_req) return 2;
        if (mode == 2 && resume)   return 1;
        return mode;
    endfunction

    function automatic logic [3:0] mdl_mask(input logic [31:0] cur, input int g);
        int         slot = int'(cur % 32'(g)) / 4;
        logic [3:0] m    = '0;
        for (int i = 0; i < g / 4; i++) m[i] = (i >= slot);
        return m;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_pc[k]   <= 32'h8000_0000;
                m_mode[k] <= 0;
                m_fire[k] <= 1'b0;
                m_mis[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_pc[k]   <= mdl_next_pc(m_pc[k], m_mode[k], g_bytes[k]);
                m_mode[k] <= mdl_mode(m_mode[k]);
                m_fire[k] <= (m_mode[k] == 1) && pc_ready;
                m_mis[k]  <= mdl_mis(m_mode[k]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("d1_pc",     p1_pc,            m_pc[0]);
            chk("d1_valid",  32'(p1_valid),    32'(m_mode[0] == 1));
            chk("d1_halted", 32'(p1_halted),   32'(m_mode[0] == 2));
            chk("d1_mask",   32'(p1_mask),     32'(mdl_mask(m_pc[0], 4)));
            chk("d1_fire",   32'(p1_fire),     32'(m_fire[0]));
            chk("d1_mis",    32'(p1_mis),      32'(m_mis[0]));
            chk("d4_pc",     p4_pc,            m_pc[1]);
            chk("d4_valid",  32'(p4_valid),    32'(m_mode[1] == 1));
            chk("d4_halted", 32'(p4_halted),   32'(m_mode[1] == 2));
            chk("d4_mask",   32'(p4_mask),     32'(mdl_mask(m_pc[1], 16)));
            chk("d4_fire",   32'(p4_fire),     32'(m_fire[1]));
            chk("d4_mis",    32'(p4_mis),      32'(m_mis[1]));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_req();
        trap_redirect = 1'b0;
        br_redirect   = 1'b0;
        halt_req      = 1'b0;
        resume        = 1'b0;
    endtask

    initial begin
        pc_ready = 1'b1;
        cmp_en   = 1'b1;
        repeat (3) tick();
        chk("rst_pc",    p1_pc,           32'h8000_0000);
        chk("rst_valid", 32'(p1_valid),   32'd0);
        rst = 1'b1;
        tick();
        chk("boot_pc0",    p1_pc,         32'h8000_0000);
        chk("boot_valid",  32'(p1_valid), 32'd1);
        tick();
        chk("seq_pc1",   p1_pc,           32'h8000_0004);
        chk("seq_fire1", 32'(p1_fire),    32'd1);
        chk("seq4_pc1",  p4_pc,           32'h8000_0010);
        tick();
        chk("seq_pc2",   p1_pc,           32'h8000_0008);
        repeat (2) tick();
        chk("pre_stall", p1_pc,           32'h8000_0010);

        pc_ready = 1'b0;
        tick();
        chk("stall_pc",   p1_pc,          32'h8000_0010);
        chk("stall_fire", 32'(p1_fire),   32'd0);
        br_redirect = 1'b1; br_target = 32'h8000_0100;
        tick();
        clear_req();
        chk("stall_redir_pc",   p1_pc,        32'h8000_0100);
        chk("stall_redir_fire", 32'(p1_fire), 32'd0);

        pc_ready = 1'b1;
        trap_redirect = 1'b1; trap_target = 32'h8000_0200;
        br_redirect   = 1'b1; br_target   = 32'h8000_0300;
        tick();
        clear_req();
        chk("both_redir_pc", p1_pc, 32'h8000_0200);

        br_redirect = 1'b1; br_target = 32'h8000_0102;
        tick();
        clear_req();
        chk("misalign_pc",  p1_pc,        32'h8000_0100);
        chk("misalign_err", 32'(p1_mis),  32'd1);
        tick();
        chk("misalign_end", 32'(p1_mis),  32'd0);

        br_redirect = 1'b1; br_target = 32'h8000_0018;
        tick();
        clear_req();
        chk("w4_mid_pc",   p4_pc,       32'h8000_0018);
        chk("w4_mid_mask", 32'(p4_mask), 32'h0000_000c);
        tick();
        chk("w4_next_pc",   p4_pc,        32'h8000_0020);
        chk("w4_next_mask", 32'(p4_mask), 32'h0000_000f);

        halt_req = 1'b1;
        tick();
        clear_req();
        chk("halt_halted", 32'(p1_halted), 32'd1);
        chk("halt_valid",  32'(p1_valid),  32'd0);
        trap_redirect = 1'b1; trap_target = 32'h0000_0000;
        tick();
        clear_req();
        chk("halt_trap_pc", p1_pc, 32'h0000_0000);
        tick();
        resume = 1'b1; halt_req = 1'b1;
        tick();
        clear_req();
        chk("resume_halted", 32'(p1_halted), 32'd0);
        chk("resume_pc",     p1_pc,          32'h0000_0000);
        tick();
        chk("resume_next", p1_pc, 32'h0000_0004);

        br_redirect = 1'b1; br_target = 32'hFFFF_FFFC;
        tick();
        clear_req();
        chk("wrap_top",    p1_pc,        32'hFFFF_FFFC);
        chk("wrap4_mask",  32'(p4_mask), 32'h0000_0008);
        tick();
        chk("wrap_pc",  p1_pc, 32'h0000_0000);
        chk("wrap4_pc", p4_pc, 32'h0000_0000);

        trap_redirect = 1'b1; trap_target = 32'h8000_0040; halt_req = 1'b1;
        tick();
        clear_req();
        chk("redir_halt_pc", p1_pc,          32'h8000_0040);
        chk("redir_halt_h",  32'(p1_halted), 32'd1);
        trap_redirect = 1'b1; trap_target = 32'h8000_0042;
        tick();
        clear_req();
        chk("halt_mis", 32'(p1_mis), 32'd1);

        #2 rst = 1'b0;
        #1;
        chk("arst_pc",     p1_pc,           32'h8000_0000);
        chk("arst_valid",  32'(p1_valid),   32'd0);
        chk("arst_halted", 32'(p1_halted),  32'd0);
        chk("arst_mis",    32'(p1_mis),     32'd0);
        chk("arst_fire",   32'(p1_fire),    32'd0);
        chk("arst4_pc",    p4_pc,           32'h8000_0000);
        chk("arst4_mask",  32'(p4_mask),    32'h0000_000f);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("rerun_pc",    p1_pc,         32'h8000_0004);
        chk("rerun_valid", 32'(p1_valid), 32'd1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_pc_gen.md
# ifu_pc_gen

Parametrised program-counter generator at the head of the IFU.
- Holds the fetch PC and presents it to the fetch stage over a valid/ready handshake.
- Supports fetch groups of 1, 2 or 4 instructions, with per-lane valid masks.
- Applies prioritised trap and branch redirects, runs a small boot/run/halt state machine, and reports misaligned redirect targets.
- Replaces the single-width, stall-only PC counter of the earlier pipeline.

## Interface
Parameters:
- XLEN, 32: PC width in bits.
- RST_PC, 32'h8000_0000: PC loaded on reset; must be aligned to 4 bytes.
- FETCH_W, 1: instructions per fetch group; legal values 1, 2, 4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset; asserted when 0.
- trap_redirect  in  1  redirect request from the trap/CSR unit.
- trap_target  in  XLEN  trap/mret target address.
- br_redirect  in  1  redirect request from the branch unit.
- br_target  in  XLEN  branch/jump target address.
- halt_req  in  1  ebreak/stop request.
- resume  in  1  leave HALT.
- pc_ready  in  1  fetch stage accepts the current PC.
- pc  out  XLEN  current fetch PC.
- pc_valid  out  1  pc is valid for fetch.
- lane_mask  out  FETCH_W  valid instruction slots in the current group.
- pc_fire  out  1  registered one-cycle pulse; high the cycle after a pc_valid && pc_ready handshake.
- misalign_err  out  1  registered one-cycle pulse; high the cycle after an accepted redirect whose target had bits[1:0] != 0.
- halted  out  1  high while the state machine is in HALT.

## Operation
- States:
  - BOOT, entered on reset.
  - RUN.
  - HALT.
- Transitions:
  - BOOT -> RUN unconditionally on the first edge after reset release.
  - RUN -> HALT on halt_req.
  - HALT -> RUN on resume.
- Group size G = FETCH_W*4 bytes.
- lane_mask bit i = 1 iff i >= pc[log2(G)-1:2]. A redirect into the middle of a group masks the lower slots; FETCH_W=1 gives lane_mask = 1.
- Sequential next PC = (pc & ~(G-1)) + G. Modulo-2^XLEN arithmetic, so 0xFFFF_FFFC with FETCH_W=1 wraps to 0.
- PC update per edge in RUN, highest priority first:
  1. trap_redirect: pc <= {trap_target[XLEN-1:2], 2'b00}.
  2. br_redirect: pc <= {br_target[XLEN-1:2], 2'b00}.
  3. pc_valid && pc_ready: pc <= sequential next PC.
  4. Otherwise pc holds (stall).
- A redirect while pc_valid && !pc_ready discards the stalled PC; it is never handed out.
- Both redirects high: trap wins, the branch is dropped. misalign_err reflects only the winning target.
- misalign_err pulses for the accepted target only, and the PC is still updated with the forced-aligned value.
- halt_req in the same cycle as a redirect: the redirect updates pc and the state moves to HALT. pc_valid drops the next cycle and the redirected PC is fetched after resume.
- In HALT:
  - pc_valid = 0 and no handshakes occur.
  - Redirects still update pc (same priority) so resume continues from the latest target.
  - halt_req is ignored.
  - resume and halt_req together: resume wins.
- pc_valid = 1 exactly in RUN. It stays high across redirects, since a redirect replaces pc without a bubble cycle.

## Timing
- Reset (rst = 0, any time, including mid-handshake or mid-HALT). All of the following take effect immediately, without waiting for a clock edge:
  - pc = RST_PC, state = BOOT.
  - pc_valid = 0, pc_fire = 0, misalign_err = 0, halted = 0.
  - lane_mask = mask of RST_PC.
- After release: BOOT for 1 cycle, then RUN with pc_valid = 1 and pc = RST_PC.
- Redirect latency: a request sampled at edge N is visible on pc after edge N. No combinational path from trap_target or br_target to pc.
- pc, pc_valid, lane_mask and halted are registered or decoded from registers only. pc_ready only affects next-state logic.
- pc_fire and misalign_err are flops and last exactly one cycle per event.
- halted rises the cycle after the edge that enters HALT and falls the cycle after the edge that takes resume.

## Structure
- Add to the shared defines package:
  - state enum ifu_pcgen_state_e {BOOT, RUN, HALT}.
  - the RST_PC default constant.
  - the FETCH_W legality check (elaboration-time assertion).
- One natural sub-module: ifu_pc_lane_mask, purely combinational (pc offset -> lane_mask), reusable by the fetch aligner.
- Everything else stays in a single module: next-PC mux, state register, pulse flops.

## Test plan
- Reset with FETCH_W=1: hold rst = 0 for 3 cycles, then release with pc_ready = 1 -> one BOOT cycle with pc_valid = 0, then pc = 0x8000_0000, 0x8000_0004, 0x8000_0008 with pc_fire high the cycle after each.
- Stall and redirect: pc_ready = 0 at pc 0x8000_0010, br_redirect to 0x8000_0100 -> pc = 0x8000_0100 next cycle and 0x8000_0010 is never accepted.
- Simultaneous redirects: trap to 0x8000_0200 and branch to 0x8000_0300 in the same cycle -> pc = 0x8000_0200.
- Misaligned target: br_target = 0x8000_0102 -> pc = 0x8000_0100 and misalign_err pulses for one cycle.
- FETCH_W=4: redirect to 0x8000_0018 -> lane_mask = 4'b1100, then pc = 0x8000_0020 with lane_mask = 4'b1111.
- Halt/resume and wrap:
  - halt_req, then a trap to 0x0 while halted, then resume -> halted high, pc_valid low, then resumes at pc = 0.
  - With FETCH_W=1 at pc 0xFFFF_FFFC -> next pc = 0.
  - Async reset asserted mid-HALT -> all outputs at reset values immediately.
